// File: rtl/uart_tx_fifo.sv
// UART transmitter with runtime divisor/parity/stop config fed by a small FIFO.
// First start bit one cycle after accept into an idle, empty FIFO; s_ready low only while FIFO full.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] fifo_head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 bit_end;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     baud_q, baud_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  assign s_ready    = (level_q != FULL_LVL);
  assign push       = s_valid && s_ready;
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign bit_end    = (baud_q == div_q);

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= s_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    load      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (level_q != '0) begin
          load = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          baud_d    = '0;
          bit_cnt_d = '0;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          baud_d    = '0;
          bit_cnt_d = '0;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = 4'd1;
          end else if (level_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame start: config is sampled here only, so mid-frame changes wait for the next frame.
    if (load) begin
      pop       = 1'b1;
      shift_d   = fifo_head;
      div_d     = clk_div;
      par_en_d  = parity_en;
      par_bit_d = (^fifo_head) ^ parity_odd;
      stop2_d   = stop2;
      baud_d    = '0;
      bit_cnt_d = '0;
      state_d   = ST_START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8-bit and a 7-bit instance checked cycle by cycle against a frame-list model.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] clk_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;

  logic        s_valid8;
  logic [7:0]  s_data8;
  logic        s_ready8;
  logic        tx8;
  logic        busy8;
  logic [2:0]  level8;

  logic        s_valid7;
  logic [6:0]  s_data7;
  logic        s_ready7;
  logic        tx7;
  logic        busy7;
  logic [2:0]  level7;

  int vectors;
  int miscompares;
  int cyc;

  logic exp_tx[$];
  logic exp_busy[$];
  logic cap_tx[1024];
  logic cap_busy[1024];

  uart_tx_fifo #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .s_valid(s_valid8), .s_data(s_data8),
    .s_ready(s_ready8), .tx(tx8), .busy(busy8), .fifo_level(level8)
  );

  uart_tx_fifo #(.DATA_BITS(7), .DIV_W(16), .FIFO_DEPTH(4)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .s_valid(s_valid7), .s_data(s_data7),
    .s_ready(s_ready7), .tx(tx7), .busy(busy7), .fifo_level(level7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a frame is a list of line levels, each stretched to div+1 cycles.
  task automatic model_reset();
    exp_tx.delete();
    exp_busy.delete();
    exp_tx.push_back(1'b1);
    exp_busy.push_back(1'b0);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic add_frame(input logic [31:0] data, input int nbits, input int div,
                           input logic pen, input logic podd, input logic st2);
    logic        bits[$];
    logic [31:0] mask;
    logic        p;
    mask = (32'd1 << nbits) - 32'd1;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (pen) begin
      p = 1'(($countones(data & mask)) % 2) ^ podd;
      bits.push_back(p);
    end
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int r = 0; r <= div; r++) begin
        exp_tx.push_back(bits[k]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic capture(input logic use7, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]   = use7 ? tx7 : tx8;
      cap_busy[i] = use7 ? busy7 : busy8;
    end
  endtask

  task automatic push8(input logic [7:0] d);
    s_valid8 = 1'b1;
    s_data8  = d;
    @(posedge clk);
    #1;
    s_valid8 = 1'b0;
  endtask

  task automatic set_cfg(input int div, input logic pen, input logic podd, input logic st2);
    clk_div    = 16'(div);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = st2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || s_ready8 !== 1'b1 || level8 !== 3'd0) begin
      miscompares++;
      $display("FAIL reset8: tx=%b busy=%b rdy=%b lvl=%0d, expected 1 0 1 0", tx8, busy8, s_ready8, level8);
    end
    vectors++;
    if (tx7 !== 1'b1 || busy7 !== 1'b0 || s_ready7 !== 1'b1 || level7 !== 3'd0) begin
      miscompares++;
      $display("FAIL reset7: tx=%b busy=%b rdy=%b lvl=%0d, expected 1 0 1 0", tx7, busy7, s_ready7, level7);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int nbusy;
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    model_reset();
    add_frame(32'h55, 8, 3, 1'b0, 1'b0, 1'b0);
    add_idle(4);
    push8(8'h55);
    capture(1'b0, exp_tx.size());
    nbusy = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      nbusy += int'(cap_busy[i] === 1'b1);
      vectors++;
      if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
        miscompares++;
        $display("FAIL basic_wave @%0d: tx=%b busy=%b, expected tx=%b busy=%b", i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
    vectors++;
    if (nbusy !== 40) begin
      miscompares++;
      $display("FAIL basic_busy_len: got %0d cycles, expected 40", nbusy);
    end
  endtask

  task automatic test_parity();
    logic want;
    for (int odd = 0; odd < 2; odd++) begin
      set_cfg(2, 1'b1, 1'(odd), 1'b0);
      model_reset();
      add_frame(32'h07, 8, 2, 1'b1, 1'(odd), 1'b0);
      add_idle(3);
      push8(8'h07);
      capture(1'b0, exp_tx.size());
      for (int i = 0; i < exp_tx.size(); i++) begin
        vectors++;
        if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
          miscompares++;
          $display("FAIL parity_wave odd=%0d @%0d: tx=%b busy=%b, expected tx=%b busy=%b", odd, i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
        end
      end
      want = (odd == 0) ? 1'b1 : 1'b0;
      vectors++;
      if (cap_tx[1 + 9 * 3] !== want) begin
        miscompares++;
        $display("FAIL parity_bit odd=%0d: got %b, expected %b", odd, cap_tx[1 + 9 * 3], want);
      end
      vectors++;
      if (cap_busy[33] !== 1'b1 || cap_busy[34] !== 1'b0) begin
        miscompares++;
        $display("FAIL parity_len odd=%0d: busy[33]=%b busy[34]=%b, expected 1 0", odd, cap_busy[33], cap_busy[34]);
      end
    end
  endtask

  task automatic test_stop2();
    int nbusy;
    set_cfg(1, 1'b0, 1'b0, 1'b1);
    model_reset();
    add_frame(32'hA0, 8, 1, 1'b0, 1'b0, 1'b1);
    add_idle(3);
    push8(8'hA0);
    capture(1'b0, exp_tx.size());
    nbusy = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      nbusy += int'(cap_busy[i] === 1'b1);
      vectors++;
      if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
        miscompares++;
        $display("FAIL stop2_wave @%0d: tx=%b busy=%b, expected tx=%b busy=%b", i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
    vectors++;
    if (nbusy !== 22) begin
      miscompares++;
      $display("FAIL stop2_len: got %0d cycles, expected 22", nbusy);
    end
    stop2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e1;
    int e6;
    int waited;
    set_cfg(7, 1'b0, 1'b0, 1'b0);
    model_reset();
    for (int k = 0; k < 6; k++) add_frame(32'h11 + 32'(k), 8, 7, 1'b0, 1'b0, 1'b0);
    add_idle(4);
    e1 = 0;
    e6 = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          s_valid8 = 1'b1;
          s_data8  = 8'h11 + 8'(k);
          vectors++;
          if (s_ready8 !== ((k < 5) ? 1'b1 : 1'b0)) begin
            miscompares++;
            $display("FAIL b2b_ready word%0d: got %b, expected %b", k, s_ready8, (k < 5));
          end
          if (k == 5) begin
            waited = 0;
            while (s_ready8 !== 1'b1 && waited < 500) begin
              @(posedge clk);
              #1;
              waited++;
            end
            vectors++;
            if (waited >= 500) begin
              miscompares++;
              $display("FAIL b2b_timeout: s_ready still %b, expected 1 within 500 cycles", s_ready8);
            end
          end
          @(posedge clk);
          #1;
          if (k == 0) e1 = cyc;
          if (k == 5) e6 = cyc;
        end
        s_valid8 = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        capture(1'b0, exp_tx.size());
      end
    join
    for (int i = 0; i < exp_tx.size(); i++) begin
      vectors++;
      if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
        miscompares++;
        $display("FAIL b2b_wave @%0d: tx=%b busy=%b, expected tx=%b busy=%b", i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
    vectors++;
    if (e6 - e1 !== 82) begin
      miscompares++;
      $display("FAIL b2b_sixth_accept: accepted %0d cycles after first, expected 82", e6 - e1);
    end
  endtask

  task automatic test_width7();
    int nbusy;
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    model_reset();
    add_frame(32'h7F, 7, 0, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    s_valid7 = 1'b1;
    s_data7  = 7'h7F;
    @(posedge clk);
    #1;
    s_valid7 = 1'b0;
    fork
      capture(1'b1, exp_tx.size());
      begin
        repeat (3) @(negedge clk);
        #1 stop2 = 1'b1;
      end
    join
    stop2 = 1'b0;
    nbusy = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      nbusy += int'(cap_busy[i] === 1'b1);
      vectors++;
      if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
        miscompares++;
        $display("FAIL w7_wave @%0d: tx=%b busy=%b, expected tx=%b busy=%b", i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
    vectors++;
    if (nbusy !== 9) begin
      miscompares++;
      $display("FAIL w7_len: got %0d cycles, expected 9", nbusy);
    end
  endtask

  task automatic test_random();
    int          div;
    logic        pen;
    logic        podd;
    logic        st2;
    int          nw;
    logic [7:0]  words[3];
    for (int it = 0; it < 20; it++) begin
      div  = $urandom_range(0, 4);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      st2  = 1'($urandom_range(0, 1));
      nw   = $urandom_range(1, 3);
      set_cfg(div, pen, podd, st2);
      model_reset();
      for (int k = 0; k < nw; k++) begin
        words[k] = 8'($urandom_range(0, 255));
        add_frame(32'(words[k]), 8, div, pen, podd, st2);
      end
      add_idle(3);
      fork
        begin
          for (int k = 0; k < nw; k++) begin
            s_valid8 = 1'b1;
            s_data8  = words[k];
            @(posedge clk);
            #1;
          end
          s_valid8 = 1'b0;
        end
        begin
          @(posedge clk);
          #1;
          capture(1'b0, exp_tx.size());
        end
      join
      for (int i = 0; i < exp_tx.size(); i++) begin
        vectors++;
        if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
          miscompares++;
          $display("FAIL rand it%0d @%0d: tx=%b busy=%b, expected tx=%b busy=%b (div=%0d pen=%b odd=%b st2=%b n=%0d)",
                   it, i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i], div, pen, podd, st2, nw);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push8(8'h3C);
    push8(8'h01);
    push8(8'h02);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (level8 !== 3'd2 || busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: lvl=%0d busy=%b, expected 2 1", level8, busy8);
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || level8 !== 3'd0 || s_ready8 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_abort: tx=%b busy=%b lvl=%0d rdy=%b, expected 1 0 0 1", tx8, busy8, level8, s_ready8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vectors++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || level8 !== 3'd0) begin
        miscompares++;
        $display("FAIL midrst_idle @%0d: tx=%b busy=%b lvl=%0d, expected 1 0 0", i, tx8, busy8, level8);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    s_valid8    = 1'b0;
    s_data8     = '0;
    s_valid7    = 1'b0;
    s_data7     = '0;
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_width7();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. Adds:
- configurable data width;
- runtime baud divisor;
- runtime parity (none/even/odd) and 1 or 2 stop bits;
- a small input FIFO behind a valid/ready handshake.

Sits between a byte-producing client (CPU register bank, DMA, debug stream) and the serial TX pin. Back-to-back frames run with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- DIV_W, 16, width of the runtime baud divisor.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_div  in  DIV_W  bit period = clk_div+1 clk cycles
- parity_en  in  1  1 = append parity bit
- parity_odd  in  1  0 = even parity, 1 = odd parity; ignored when parity_en=0
- stop2  in  1  0 = one stop bit, 1 = two stop bits
- s_valid  in  1  write request
- s_data  in  DATA_BITS  word to transmit
- s_ready  out  1  FIFO not full
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset (async assert, sync-free release): tx=1, busy=0, s_ready=1, fifo_level=0. FIFO pointers cleared, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately: tx=1, FIFO contents discarded.
- Handshake: a word is written on a rising edge with s_valid&&s_ready.
  - s_ready = (fifo_level != FIFO_DEPTH), driven combinationally from registered level.
  - s_valid while full is ignored; the data is dropped and must be held by the client.
- FIFO: simultaneous push and pop leaves fifo_level unchanged. Pop occurs only from the FSM.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0.
  - If fifo_level != 0: pop head into shifter; latch clk_div, parity_en, parity_odd, stop2 into frame-config registers; go to START.
  - Latency: a word written into an empty FIFO at edge E gives tx=0 and busy=1 after edge E+1.
- Bit timing: each bit is held exactly clk_div+1 cycles, counted by a DIV_W baud counter reset at every bit boundary. clk_div=0 gives 1 cycle per bit.
- START: tx=0 for one bit period, then DATA.
- DATA: DATA_BITS bit periods, LSB first; the shifter shifts right at each bit boundary.
  - Exits to PARITY if the latched parity_en=1, else to STOP.
- PARITY: tx = ^data XOR latched parity_odd, for one bit period.
- STOP: tx=1 for 1 or 2 bit periods per latched stop2.
  - At the final stop-bit boundary, if the FIFO is non-empty: pop and re-latch config, enter START directly. tx goes low on that same edge, busy stays 1, no idle cycle.
  - Otherwise go to IDLE and busy falls on that edge.
- Config inputs changing mid-frame have no effect until the next frame start.
- Frame length in cycles = (clk_div+1) × (1 + DATA_BITS + parity_en + 1 + stop2).
- tx and busy are registered outputs; no combinational path from inputs to tx.

Test Plan:
1. DATA_BITS=8, clk_div=3, no parity, stop2=0; write 0x55.
   -> tx low 1 cycle after accept; bit sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy high exactly 40 cycles, then tx=1.
2. parity_en=1, parity_odd=0, write 0x07 -> parity bit 1. Repeat with parity_odd=1 -> parity bit 0. Frame 11 bit periods.
3. stop2=1, clk_div=1, write 0xA0 -> stop high for 4 cycles; total frame 22 cycles.
4. clk_div=7, FIFO_DEPTH=4; write 6 words 0x11..0x16 on consecutive cycles.
   -> s_ready drops after the 5th accept (one already popped); 6th held until first frame ends.
   -> frames back-to-back with no idle cycle between last stop and next start; order preserved.
5. Assert rst_n low mid-DATA of 0x3C with 2 words queued -> tx=1, busy=0, fifo_level=0 immediately; after release, line stays idle.
6. DATA_BITS=7 build, clk_div=0, write 0x7F -> 9-cycle frame: 0,1,1,1,1,1,1,1,1. Change stop2 mid-frame -> current frame unaffected.
